// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: runs mult/multu/div/divu and owns HI/LO.
// Latency: MULT_CYCLES or DIV_CYCLES for mult/div (Busy high that long); mthi/mtlo write in one cycle.
// Backpressure: none internally; Busy tells the hazard unit to stall, and new work arriving while Busy is ignored.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic        w_accept;
    logic        w_done;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_is_mdu_op;

    // Result computed at the accepting edge and held until completion.
    logic [31:0] r_tmp_hi;
    logic [31:0] r_tmp_lo;
    logic        r_tmp_wr;

    logic [31:0] HI_r;
    logic [31:0] LO_r;

    // ---------------------------------------------------------------
    // Arithmetic, evaluated on the live operands; only the accepting
    // edge captures it, so later operand changes have no effect.
    // ---------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [31:0] w_dvs_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_zero;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_wr;

    assign w_is_mdu_op = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
                         (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);

    // Sign-extend to 64 bits so the low 64 bits of the product are the signed result.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed division runs on magnitudes and re-applies signs afterwards. This
    // also yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    assign w_div_signed = (MDUOp == OP_DIV);
    assign w_dvd_mag    = (w_div_signed && A[31]) ? (~A + 32'd1) : A;
    assign w_dvs_mag    = (w_div_signed && B[31]) ? (~B + 32'd1) : B;
    assign w_div_zero   = (B == 32'd0);
    // Substitute a harmless divisor for zero; the result is discarded anyway.
    assign w_dvs_safe   = w_div_zero ? 32'd1 : w_dvs_mag;
    assign w_q_mag      = w_dvd_mag / w_dvs_safe;
    assign w_r_mag      = w_dvd_mag % w_dvs_safe;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign w_quot = (w_div_signed && (A[31] ^ B[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem  = (w_div_signed && A[31])           ? (~w_r_mag + 32'd1) : w_r_mag;

    // Select the result and whether it will be written back at completion.
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_wr = 1'b0;
        case (MDUOp)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
                w_res_wr = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
                w_res_wr = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
                w_res_wr = !w_div_zero;
            end
            default: begin
                w_res_wr = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------

    // State and countdown registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, countdown and the one-cycle strobes that drive the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A flushed instruction (Req) leaves every piece of state alone.
                if (!Req) begin
                    if (Start && w_is_mdu_op) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = ((MDUOp == OP_MULT) || (MDUOp == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
                    end else if (!Start && (MDUOp == OP_MTHI)) begin
                        w_mthi = 1'b1;
                    end else if (!Start && (MDUOp == OP_MTLO)) begin
                        w_mtlo = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Start, mthi/mtlo and Req are all ignored while running.
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------

    // Capture the pending result when an operation is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmp_hi <= 32'd0;
            r_tmp_lo <= 32'd0;
            r_tmp_wr <= 1'b0;
        end else if (w_accept) begin
            r_tmp_hi <= w_res_hi;
            r_tmp_lo <= w_res_lo;
            r_tmp_wr <= w_res_wr;
        end
    end

    // Architectural HI/LO: written on completion or by mthi/mtlo.
    always_ff @(posedge clk) begin
        if (reset) begin
            HI_r <= 32'd0;
            LO_r <= 32'd0;
        end else if (w_done) begin
            if (r_tmp_wr) begin
                HI_r <= r_tmp_hi;
                LO_r <= r_tmp_lo;
            end
        end else begin
            if (w_mthi) begin
                HI_r <= A;
            end
            if (w_mtlo) begin
                LO_r <= A;
            end
        end
    end

    assign Busy = (r_state == S_RUN);
    assign HI   = HI_r;
    assign LO   = LO_r;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: behavioural reference model checked every cycle, plus literal expectations.
// Timing: inputs change 1 time unit after the rising edge; model updates on the edge; compare runs on the falling edge.
// Every wait on Busy is bounded; an expired bound is reported as a failure.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_tests;
    int n_fail;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .Req   (Req),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pwr;
    int          m_left;
    logic        chk_en;
    longint      sa, sb, sq, sr;
    logic [63:0] p64;

    always @(posedge clk) begin
        if (reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_pwr = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (!Req) begin
            if (Start && MDUOp >= 3'd1 && MDUOp <= 3'd4) begin
                sa = longint'($signed(A));
                sb = longint'($signed(B));
                m_pwr = 1'b1;
                case (MDUOp)
                    3'd1: begin p64 = 64'(sa * sb); m_left = 5; end
                    3'd2: begin p64 = {32'd0, A} * {32'd0, B}; m_left = 5; end
                    3'd3: begin
                        m_left = 10;
                        if (B == 0) m_pwr = 1'b0;
                        else begin sq = sa / sb; sr = sa % sb; p64 = {sr[31:0], sq[31:0]}; end
                    end
                    default: begin
                        m_left = 10;
                        if (B == 0) m_pwr = 1'b0;
                        else p64 = {A % B, A / B};
                    end
                endcase
                m_phi = p64[63:32];
                m_plo = p64[31:0];
            end else if (!Start && MDUOp == 3'd5) begin
                m_hi = A;
            end else if (!Start && MDUOp == 3'd6) begin
                m_lo = A;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests = n_tests + 3;
            if (Busy !== (m_left > 0)) begin
                n_fail++;
                $display("FAIL model_busy t=%0t got %b want %b", $time, Busy, (m_left > 0));
            end
            if (HI !== m_hi) begin
                n_fail++;
                $display("FAIL model_hi t=%0t got %08h want %08h", $time, HI, m_hi);
            end
            if (LO !== m_lo) begin
                n_fail++;
                $display("FAIL model_lo t=%0t got %08h want %08h", $time, LO, m_lo);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %08h want %08h", name, got, want);
        end
    endtask

    // Present one instruction for a single cycle, then return inputs to idle.
    task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic rq);
        Start = st; MDUOp = op; A = a; B = b; Req = rq;
        step();
        Start = 1'b0; MDUOp = 3'd0; Req = 1'b0;
    endtask

    // Count cycles until Busy drops, bounded.
    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout got busy_after %0d want idle", name, n);
        end
    endtask

    int n;

    initial begin
        n_tests = 0; n_fail = 0; chk_en = 1'b0;
        reset = 1'b1; Start = 1'b0; MDUOp = 3'd0; A = 0; B = 0; Req = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;

        // Reset state held across idle cycles.
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", {31'd0, Busy}, 32'd0);
            check("rst_hi", HI, 32'd0);
            check("rst_lo", LO, 32'd0);
            step();
        end

        // mult -2 * 3
        drive(1, 3'd1, 32'hFFFF_FFFE, 32'd3, 0);
        wait_idle("mult", n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);

        // multu same operands
        drive(1, 3'd2, 32'hFFFF_FFFE, 32'd3, 0);
        wait_idle("multu", n);
        check("multu_cycles", n, 32'd5);
        check("multu_hi", HI, 32'h0000_0002);
        check("multu_lo", LO, 32'hFFFF_FFFA);

        // div -7 / 2
        drive(1, 3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        wait_idle("div", n);
        check("div_cycles", n, 32'd10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // divu 7 / 2
        drive(1, 3'd4, 32'd7, 32'd2, 0);
        wait_idle("divu", n);
        check("divu_cycles", n, 32'd10);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);

        // mthi / mtlo preload, then divide by zero leaves them alone
        drive(0, 3'd5, 32'h11, 32'd0, 0);
        drive(0, 3'd6, 32'h22, 32'd0, 0);
        check("mthi", HI, 32'h11);
        check("mtlo", LO, 32'h22);
        drive(1, 3'd3, 32'd5, 32'd0, 0);
        wait_idle("div0", n);
        check("div0_cycles", n, 32'd10);
        check("div0_hi", HI, 32'h11);
        check("div0_lo", LO, 32'h22);

        // Flushed mult and flushed mtlo
        drive(1, 3'd1, 32'd4, 32'd4, 1);
        check("flush_busy", {31'd0, Busy}, 32'd0);
        step();
        check("flush_busy2", {31'd0, Busy}, 32'd0);
        check("flush_hi", HI, 32'h11);
        check("flush_lo", LO, 32'h22);
        drive(0, 3'd6, 32'h99, 32'd0, 1);
        check("flush_mtlo", LO, 32'h22);

        // Most-negative / -1
        drive(1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        wait_idle("divovf", n);
        check("divovf_lo", LO, 32'h8000_0000);
        check("divovf_hi", HI, 32'd0);

        // Operands change during RUN
        drive(1, 3'd1, 32'd6, 32'd7, 0);
        A = 32'h0000_FFFF; B = 32'h1234_5678;
        step();
        A = 32'hDEAD_BEEF; B = 32'h0000_0003;
        wait_idle("opchg", n);
        check("opchg_hi", HI, 32'd0);
        check("opchg_lo", LO, 32'd42);

        // New work while Busy is ignored
        drive(1, 3'd4, 32'd100, 32'd7, 0);
        step();
        drive(1, 3'd1, 32'd9, 32'd9, 0);
        drive(0, 3'd5, 32'h55, 32'd0, 0);
        wait_idle("busyign", n);
        check("busyign_lo", LO, 32'd14);
        check("busyign_hi", HI, 32'd2);
        step();
        check("busyign_idle", {31'd0, Busy}, 32'd0);

        // Req during RUN does not cancel
        drive(1, 3'd1, 32'd3, 32'd5, 0);
        step();
        Req = 1'b1;
        step();
        Req = 1'b0;
        wait_idle("reqrun", n);
        check("reqrun_lo", LO, 32'd15);
        check("reqrun_hi", HI, 32'd0);

        // Reset at cycle 3 of a mult
        drive(0, 3'd5, 32'h77, 32'd0, 0);
        drive(1, 3'd1, 32'd4, 32'd4, 0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        for (int i = 0; i < 8; i++) step();
        check("midrst_late_lo", LO, 32'd0);
        check("midrst_late_hi", HI, 32'd0);

        // Start together with reset
        reset = 1'b1;
        drive(1, 3'd1, 32'd2, 32'd2, 0);
        reset = 1'b0;
        check("startrst_busy", {31'd0, Busy}, 32'd0);
        for (int i = 0; i < 6; i++) step();
        check("startrst_lo", LO, 32'd0);

        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the E stage of the five-stage MIPS pipeline. Sits directly downstream of the instruction decoder's Start/MDUOp outputs and E-stage operand forwarding.
- Executes mult/multu/div/divu with a fixed multi-cycle latency. Executes mthi/mtlo in one cycle.
- Holds the architectural HI/LO registers and raises Busy so the hazard unit can stall mfhi/mflo and further MDU instructions.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu.
- DIV_CYCLES, 10, cycles Busy stays high for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse: a mult/multu/div/divu instruction is in E this cycle.
- MDUOp  input  3  0=Others, 1=Mult, 2=Multu, 3=Div, 4=Divu, 5=Mthi, 6=Mtlo, 7=reserved (treated as Others).
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- Req  input  1  exception/interrupt request this cycle; the E-stage instruction is being flushed.
- Busy  output  1  operation in progress.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (clk edge with reset=1):
  - HI=0, LO=0, Busy=0, counter=0, pending results cleared.
  - Reset has priority over everything, including mid-operation; an in-flight operation is discarded and HI/LO are not updated.
- States: IDLE (Busy=0) and RUN (Busy=1, counter>0).
- Accepting Start in IDLE:
  - Condition: Start=1, Req=0, MDUOp in 1..4.
  - Capture A and B. Compute the result into internal tmpHI/tmpLO.
  - Load counter with MULT_CYCLES or DIV_CYCLES. Busy=1 from the next cycle.
- RUN:
  - Counter decrements each cycle.
  - On the edge where counter goes 1->0: HI<=tmpHI, LO<=tmpLO, Busy<=0.
  - Busy is therefore high for exactly N cycles, and new HI/LO are visible the cycle Busy falls.
- Start=1 with Req=1: ignored. No state change.
- Start or mthi/mtlo while Busy=1: ignored. The hazard unit guarantees this never occurs; the bench checks that the state is unaffected.
- mthi/mtlo (MDUOp=5/6, Start=0):
  - Write A into HI/LO on the same edge, visible the next cycle.
  - Only when Req=0 and Busy=0. Busy stays 0.
- Arithmetic rules:
  - mult: signed 32x32 -> 64. {HI,LO} = product.
  - multu: the same operation, unsigned.
  - div: signed. LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - divu: unsigned.
  - B==0 for div/divu: Busy still asserts for DIV_CYCLES, but HI/LO are left unchanged at completion.
  - div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- Operand capture: A and B are sampled only on the accepting edge. Later input changes do not affect the result.
- Req during RUN: no effect. The operation already committed in an earlier instruction completes normally.
- Start and reset asserted together: reset wins.
- HI and LO are register outputs only; there is no combinational path from the inputs.

Test Plan:
- Reset then idle: HI=LO=0 and Busy=0 for 3 cycles.
- mult A=0xFFFFFFFE (-2), B=3 -> Busy high for exactly 5 cycles. When Busy falls: HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat as multu: HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy high for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu A=7, B=2 -> LO=3, HI=1.
- Divide by zero: HI/LO preloaded via mthi 0x11, mtlo 0x22; div A=5, B=0 -> Busy high for 10 cycles, then HI=0x11, LO=0x22 unchanged.
- Flush: Start with Req=1 (mult 4,4) -> Busy stays 0 and HI/LO unchanged. mtlo with Req=1 -> LO unchanged.
- Reset mid-mult at cycle 3 of 5 -> the next cycle Busy=0, HI=LO=0, and no later write occurs. Also check that changing A/B during RUN does not alter the result.
